// File: rtl/relogio_johnson_param_if.sv
// Bus bundle for relogio_johnson_param: load/alarm controls in, Johnson-coded
// time digits and status flags out. The clock core takes the slave side.
interface relogio_johnson_param_if #(
  parameter int N_FAIXAS = 4
);
  logic                LD;
  logic [1:0]          H_in1;
  logic [3:0]          H_in0;
  logic [3:0]          M_in1;
  logic [3:0]          M_in0;
  logic                modo_12h;
  logic                AL_EN;
  logic [4:0]          AL_H;
  logic [5:0]          AL_M;
  logic [4:0]          H_out1_j;
  logic [4:0]          H_out0_j;
  logic [4:0]          M_out1_j;
  logic [4:0]          M_out0_j;
  logic [4:0]          S_out1_j;
  logic [4:0]          S_out0_j;
  logic                pm;
  logic [N_FAIXAS-1:0] faixa;
  logic                tick_s;
  logic                alarme;
  logic                load_err;

  modport master (
    output LD, H_in1, H_in0, M_in1, M_in0, modo_12h, AL_EN, AL_H, AL_M,
    input  H_out1_j, H_out0_j, M_out1_j, M_out0_j, S_out1_j, S_out0_j,
           pm, faixa, tick_s, alarme, load_err
  );

  modport slave (
    input  LD, H_in1, H_in0, M_in1, M_in0, modo_12h, AL_EN, AL_H, AL_M,
    output H_out1_j, H_out0_j, M_out1_j, M_out0_j, S_out1_j, S_out0_j,
           pm, faixa, tick_s, alarme, load_err
  );
endinterface

// File: rtl/relogio_johnson_param.sv
// Parametrised HH:MM:SS real-time clock. Time is held internally as 24h BCD
// digits; the display path converts to 12h on demand and Johnson-codes every
// digit. Includes a seconds prescaler, one-hot second-band indicator,
// validated load, and a timed alarm.
module relogio_johnson_param #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int N_FAIXAS  = 4,
  parameter int ALARM_LEN = 30
) (
  input logic                   clk,
  input logic                   reset,
  relogio_johnson_param_if.slave bus
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW   = $clog2(ALARM_LEN + 1);
  localparam int BAND = 60 / N_FAIXAS;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ALARM_INIT = TW'(ALARM_LEN);

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  bcd_time_t       cur;
  bcd_time_t       nxt;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   al_timer;
  logic            alarme_q;
  logic            load_err_q;
  logic            tick;
  logic            load_ok;
  logic            al_match;
  logic [5:0]      h_bin;
  logic [5:0]      s_bin;
  logic [3:0]      disp_h1;
  logic [3:0]      disp_h0;
  logic            pm_w;
  logic [N_FAIXAS-1:0] faixa_w;

  function automatic logic [4:0] johnson(input logic [3:0] d);
    case (d)
      4'd0:    return 5'b00000;
      4'd1:    return 5'b00001;
      4'd2:    return 5'b00011;
      4'd3:    return 5'b00111;
      4'd4:    return 5'b01111;
      4'd5:    return 5'b11111;
      4'd6:    return 5'b11110;
      4'd7:    return 5'b11100;
      4'd8:    return 5'b11000;
      4'd9:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] units);
    return 6'(tens) * 6'd10 + 6'(units);
  endfunction

  // A second elapses when the prescaler wraps; any load request suppresses it.
  assign tick = (presc == PRESC_MAX) && !bus.LD;

  assign load_ok = (bus.H_in1 <= 2'd2) && (bus.H_in0 <= 4'd9) &&
                   ((bus.H_in1 != 2'd2) || (bus.H_in0 <= 4'd3)) &&
                   (bus.M_in1 <= 4'd5) && (bus.M_in0 <= 4'd9);

  // Time one second ahead of the current one, with BCD carries and day wrap.
  always_comb begin
    // NOTE: assign a default first so every path drives nxt and no latch is inferred.
    nxt = cur;
    if (cur.s0 != 4'd9) begin
      nxt.s0 = cur.s0 + 4'd1;
    end else begin
      nxt.s0 = 4'd0;
      if (cur.s1 != 4'd5) begin
        nxt.s1 = cur.s1 + 4'd1;
      end else begin
        nxt.s1 = 4'd0;
        if (cur.m0 != 4'd9) begin
          nxt.m0 = cur.m0 + 4'd1;
        end else begin
          nxt.m0 = 4'd0;
          if (cur.m1 != 4'd5) begin
            nxt.m1 = cur.m1 + 4'd1;
          end else begin
            nxt.m1 = 4'd0;
            if (cur.h1 == 2'd2 && cur.h0 == 4'd3) begin
              nxt.h1 = 2'd0;
              nxt.h0 = 4'd0;
            end else if (cur.h0 == 4'd9) begin
              nxt.h1 = cur.h1 + 2'd1;
              nxt.h0 = 4'd0;
            end else begin
              nxt.h0 = cur.h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // The alarm fires only on the tick that lands exactly on AL_H:AL_M:00.
  assign al_match = bus.AL_EN &&
                    (6'(bus.AL_H) == to_bin({2'b00, nxt.h1}, nxt.h0)) &&
                    (bus.AL_M == to_bin(nxt.m1, nxt.m0)) &&
                    (nxt.s1 == 4'd0) && (nxt.s0 == 4'd0);

  // Timekeeping: load takes priority over the tick; invalid loads leave state alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur   <= '0;
      presc <= '0;
    end else if (bus.LD) begin
      if (load_ok) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        cur   <= '{h1: bus.H_in1, h0: bus.H_in0, m1: bus.M_in1, m0: bus.M_in0,
                   s1: 4'd0, s0: 4'd0};
        presc <= '0;
      end
    end else if (tick) begin
      cur   <= nxt;
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Rejected-load flag, high for the cycle after an invalid LD edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= bus.LD && !load_ok;
    end
  end

  // Alarm: trigger on a matching tick, count down one per tick, disable clears at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarme_q <= 1'b0;
      al_timer <= '0;
    end else if (!bus.AL_EN) begin
      alarme_q <= 1'b0;
      al_timer <= '0;
    end else if (tick) begin
      if (al_match) begin
        alarme_q <= 1'b1;
        al_timer <= ALARM_INIT;
      end else if (al_timer != '0) begin
        al_timer <= al_timer - TW'(1);
        if (al_timer == TW'(1)) alarme_q <= 1'b0;
      end
    end
  end

  assign h_bin = to_bin({2'b00, cur.h1}, cur.h0);
  assign s_bin = to_bin(cur.s1, cur.s0);

  // Hour display digits: 24h straight through, or 12h with midnight shown as 12.
  always_comb begin
    disp_h1 = {2'b00, cur.h1};
    disp_h0 = cur.h0;
    pm_w    = 1'b0;
    if (bus.modo_12h) begin
      if (h_bin == 6'd0) begin
        disp_h1 = 4'd1;
        disp_h0 = 4'd2;
      end else if (h_bin >= 6'd12) begin
        pm_w = 1'b1;
        if (h_bin >= 6'd22) begin
          disp_h1 = 4'd1;
          disp_h0 = 4'(h_bin - 6'd22);
        end else if (h_bin >= 6'd13) begin
          disp_h1 = 4'd0;
          disp_h0 = 4'(h_bin - 6'd12);
        end
      end
    end
  end

  // One-hot second band: bit k set while k*BAND <= S < (k+1)*BAND.
  always_comb begin
    faixa_w = '0;
    for (int k = 0; k < N_FAIXAS; k++) begin
      faixa_w[k] = (s_bin >= 6'(k * BAND)) && (s_bin < 6'((k + 1) * BAND));
    end
  end

  assign bus.H_out1_j = johnson(disp_h1);
  assign bus.H_out0_j = johnson(disp_h0);
  assign bus.M_out1_j = johnson(cur.m1);
  assign bus.M_out0_j = johnson(cur.m0);
  assign bus.S_out1_j = johnson(cur.s1);
  assign bus.S_out0_j = johnson(cur.s0);
  assign bus.pm       = pm_w;
  assign bus.faixa    = faixa_w;
  assign bus.tick_s   = tick;
  assign bus.alarme   = alarme_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_relogio_johnson_param.sv
// Directed bench for relogio_johnson_param with TICK_DIV=2, N_FAIXAS=4,
// ALARM_LEN=3. Inputs change and outputs are sampled 1 ns after rising edges.
module tb_relogio_johnson_param;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  relogio_johnson_param_if #(.N_FAIXAS(4)) bus ();

  relogio_johnson_param #(
    .TICK_DIV (2),
    .N_FAIXAS (4),
    .ALARM_LEN(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    bus.LD    = 1'b1;
    bus.H_in1 = h1;
    bus.H_in0 = h0;
    bus.M_in1 = m1;
    bus.M_in0 = m0;
    cyc(1);
    bus.LD    = 1'b0;
  endtask

  // Run-time guard against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.LD       = 1'b0;
    bus.H_in1    = '0;
    bus.H_in0    = '0;
    bus.M_in1    = '0;
    bus.M_in0    = '0;
    bus.modo_12h = 1'b0;
    bus.AL_EN    = 1'b0;
    bus.AL_H     = '0;
    bus.AL_M     = '0;
    #12;

    // Reset state
    check("rst_h1", bus.H_out1_j, 5'b00000);
    check("rst_h0", bus.H_out0_j, 5'b00000);
    check("rst_s0", bus.S_out0_j, 5'b00000);
    check("rst_pm", bus.pm, 1'b0);
    check("rst_faixa", bus.faixa, 4'b0001);
    check("rst_tick", bus.tick_s, 1'b0);
    check("rst_alarme", bus.alarme, 1'b0);
    check("rst_lerr", bus.load_err, 1'b0);

    // 1. Count 61 seconds, tick every 2nd cycle
    @(posedge clk); #1;
    reset = 1'b0;
    check("t1_tick0", bus.tick_s, 1'b0);
    cyc(1);
    check("t1_tick1", bus.tick_s, 1'b1);
    cyc(1);
    check("t1_tick2", bus.tick_s, 1'b0);
    check("t1_s0_first", bus.S_out0_j, 5'b00001);
    cyc(120);
    check("t1_h1", bus.H_out1_j, 5'b00000);
    check("t1_h0", bus.H_out0_j, 5'b00000);
    check("t1_m1", bus.M_out1_j, 5'b00000);
    check("t1_m0", bus.M_out0_j, 5'b00001);
    check("t1_s1", bus.S_out1_j, 5'b00000);
    check("t1_s0", bus.S_out0_j, 5'b00001);

    // 2. Load 15:30, then view in 12h mode
    do_load(2'd1, 4'd5, 4'd3, 4'd0);
    check("t2_h1", bus.H_out1_j, 5'b00001);
    check("t2_h0", bus.H_out0_j, 5'b11111);
    check("t2_m1", bus.M_out1_j, 5'b00111);
    check("t2_m0", bus.M_out0_j, 5'b00000);
    check("t2_s0", bus.S_out0_j, 5'b00000);
    check("t2_presc0", bus.tick_s, 1'b0);
    bus.modo_12h = 1'b1;
    #1;
    check("t2_12h_h1", bus.H_out1_j, 5'b00000);
    check("t2_12h_h0", bus.H_out0_j, 5'b00111);
    check("t2_12h_pm", bus.pm, 1'b1);
    bus.modo_12h = 1'b0;
    #1;
    check("t2_24h_pm", bus.pm, 1'b0);

    // 3. Day wrap from 23:59, then second-band change at S=15
    do_load(2'd2, 4'd3, 4'd5, 4'd9);
    check("t3_load_h1", bus.H_out1_j, 5'b00011);
    cyc(120);
    check("t3_wrap_h1", bus.H_out1_j, 5'b00000);
    check("t3_wrap_h0", bus.H_out0_j, 5'b00000);
    check("t3_wrap_m1", bus.M_out1_j, 5'b00000);
    check("t3_wrap_m0", bus.M_out0_j, 5'b00000);
    check("t3_wrap_s1", bus.S_out1_j, 5'b00000);
    check("t3_wrap_s0", bus.S_out0_j, 5'b00000);
    bus.modo_12h = 1'b1;
    #1;
    check("t3_mid_h1", bus.H_out1_j, 5'b00001);
    check("t3_mid_h0", bus.H_out0_j, 5'b00011);
    check("t3_mid_pm", bus.pm, 1'b0);
    bus.modo_12h = 1'b0;
    cyc(28);
    check("t3_faixa14", bus.faixa, 4'b0001);
    cyc(2);
    check("t3_faixa15", bus.faixa, 4'b0010);

    // 4. Invalid loads: hour 24, then minute tens 6 (time is 00:00:15)
    do_load(2'd2, 4'd4, 4'd0, 4'd0);
    check("t4_lerr_h", bus.load_err, 1'b1);
    check("t4_keep_s1", bus.S_out1_j, 5'b00001);
    check("t4_keep_s0", bus.S_out0_j, 5'b11111);
    check("t4_keep_presc", bus.tick_s, 1'b0);
    cyc(1);
    check("t4_lerr_clr", bus.load_err, 1'b0);
    cyc(1);
    do_load(2'd1, 4'd0, 4'd6, 4'd0);
    check("t4_lerr_m", bus.load_err, 1'b1);
    check("t4_keep2_s0", bus.S_out0_j, 5'b11110);
    check("t4_keep2_h1", bus.H_out1_j, 5'b00000);
    cyc(1);
    check("t4_lerr_clr2", bus.load_err, 1'b0);

    // 5. Alarm at 07:05, runs 3 ticks; then disable mid-alarm
    bus.AL_EN = 1'b1;
    bus.AL_H  = 5'd7;
    bus.AL_M  = 6'd5;
    do_load(2'd0, 4'd7, 4'd0, 4'd4);
    check("t5_load_al", bus.alarme, 1'b0);
    cyc(118);
    check("t5_pre_al", bus.alarme, 1'b0);
    check("t5_pre_s0", bus.S_out0_j, 5'b10000);
    cyc(2);
    check("t5_rise", bus.alarme, 1'b1);
    check("t5_rise_h0", bus.H_out0_j, 5'b11100);
    check("t5_rise_m0", bus.M_out0_j, 5'b11111);
    cyc(2);
    check("t5_hold1", bus.alarme, 1'b1);
    cyc(2);
    check("t5_hold2", bus.alarme, 1'b1);
    cyc(2);
    check("t5_fall", bus.alarme, 1'b0);

    do_load(2'd0, 4'd7, 4'd0, 4'd4);
    cyc(120);
    check("t5b_rise", bus.alarme, 1'b1);
    cyc(2);
    check("t5b_hold", bus.alarme, 1'b1);
    bus.AL_EN = 1'b0;
    cyc(1);
    check("t5b_off", bus.alarme, 1'b0);
    bus.AL_EN = 1'b1;
    cyc(2);
    check("t5b_stay_off", bus.alarme, 1'b0);

    do_load(2'd0, 4'd7, 4'd0, 4'd5);
    check("t5c_load_no_al", bus.alarme, 1'b0);

    // 6. Async reset with alarm active, then LD on a tick cycle
    do_load(2'd0, 4'd7, 4'd0, 4'd4);
    cyc(120);
    check("t6_al_before", bus.alarme, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_al", bus.alarme, 1'b0);
    check("t6_rst_h0", bus.H_out0_j, 5'b00000);
    check("t6_rst_m0", bus.M_out0_j, 5'b00000);
    check("t6_rst_faixa", bus.faixa, 4'b0001);
    check("t6_rst_tick", bus.tick_s, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1);
    check("t6_tick_cycle", bus.tick_s, 1'b1);
    bus.LD    = 1'b1;
    bus.H_in1 = 2'd1;
    bus.H_in0 = 4'd2;
    bus.M_in1 = 4'd3;
    bus.M_in0 = 4'd4;
    #1;
    check("t6_ld_masks_tick", bus.tick_s, 1'b0);
    cyc(1);
    bus.LD = 1'b0;
    check("t6_ld_h0", bus.H_out0_j, 5'b00011);
    check("t6_ld_m0", bus.M_out0_j, 5'b01111);
    check("t6_ld_s0", bus.S_out0_j, 5'b00000);
    check("t6_ld_presc", bus.tick_s, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
